// File: rtl/vend_txn_controller.sv
// Vending transaction sequencer: coin credit, purchase validation, dispenser
// handshake with timeout, and one-coin-at-a-time change/refund payout.
module vend_txn_controller #(
  parameter int PRICE_A      = 25,
  parameter int PRICE_B      = 40,
  parameter int MAX_CREDIT   = 200,
  parameter int VEND_TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin10,
  input  logic       coin25,
  input  logic       sel,
  input  logic       buy,
  input  logic       cancel,
  output logic       disp_req,
  input  logic       disp_ack,
  output logic       pay_req,
  output logic [1:0] pay_coin,
  input  logic       pay_ack,
  output logic [7:0] credit,
  output logic       busy,
  output logic       coin_reject,
  output logic       insuf,
  output logic       vend_fail,
  output logic       done
);

  // state  | meaning
  // IDLE   | accepting coins, buy and cancel
  // VEND   | disp_req held, waiting for disp_ack or timeout
  // PAYOUT | pay_req held with one coin, waiting for pay_ack
  // GAP    | one return-to-zero cycle between hopper coins
  typedef enum logic [1:0] {IDLE, VEND, PAYOUT, GAP} state_t;

  localparam int TW = (VEND_TIMEOUT > 1) ? $clog2(VEND_TIMEOUT) : 1;
  localparam logic [7:0] PA = 8'(PRICE_A);
  localparam logic [7:0] PB = 8'(PRICE_B);
  localparam logic [8:0] MAXC = 9'(MAX_CREDIT);
  localparam logic [TW-1:0] TLOAD = TW'(VEND_TIMEOUT - 1);

  state_t        state, state_nx;
  logic [7:0]    credit_q, credit_nx;
  logic [7:0]    chg, chg_nx;
  logic [7:0]    price_q, price_nx;
  logic [TW-1:0] timer, timer_nx;
  logic          reject_nx, insuf_nx, fail_nx, done_nx;
  logic [7:0]    coin_sum, price_sel, coin_val;
  logic [8:0]    credit_sum;
  logic          any_coin;

  assign any_coin   = coin10 | coin25;
  assign coin_sum   = (coin10 ? 8'd10 : 8'd0) + (coin25 ? 8'd25 : 8'd0);
  assign credit_sum = {1'b0, credit_q} + {1'b0, coin_sum};
  assign price_sel  = sel ? PB : PA;
  assign coin_val   = (chg >= 8'd25) ? 8'd25 : (chg >= 8'd10) ? 8'd10 : 8'd5;

  always_comb begin
    state_nx  = state;
    credit_nx = credit_q;
    chg_nx    = chg;
    price_nx  = price_q;
    timer_nx  = timer;
    reject_nx = 1'b0;
    insuf_nx  = 1'b0;
    fail_nx   = 1'b0;
    done_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (cancel && credit_q != 8'd0) begin
          chg_nx    = credit_q;
          credit_nx = 8'd0;
          reject_nx = any_coin;
          state_nx  = PAYOUT;
        end else if (buy) begin
          reject_nx = any_coin;
          if (credit_q >= price_sel) begin
            chg_nx    = credit_q - price_sel;
            price_nx  = price_sel;
            credit_nx = 8'd0;
            timer_nx  = TLOAD;
            state_nx  = VEND;
          end else begin
            insuf_nx = 1'b1;
          end
        end else if (any_coin) begin
          if (credit_sum > MAXC) reject_nx = 1'b1;
          else                   credit_nx = credit_sum[7:0];
        end
      end
      VEND: begin
        reject_nx = any_coin;
        if (disp_ack) begin
          if (chg != 8'd0) begin
            state_nx = PAYOUT;
          end else begin
            done_nx  = 1'b1;
            state_nx = IDLE;
          end
        end else if (timer == '0) begin
          // abandoned vend: refund the full amount that was taken
          fail_nx  = 1'b1;
          chg_nx   = chg + price_q;
          state_nx = PAYOUT;
        end else begin
          timer_nx = timer - 1'b1;
        end
      end
      PAYOUT: begin
        reject_nx = any_coin;
        if (pay_ack) begin
          chg_nx   = chg - coin_val;
          state_nx = GAP;
        end
      end
      GAP: begin
        reject_nx = any_coin;
        if (chg != 8'd0) begin
          state_nx = PAYOUT;
        end else begin
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      credit_q    <= 8'd0;
      chg         <= 8'd0;
      price_q     <= 8'd0;
      timer       <= '0;
      coin_reject <= 1'b0;
      insuf       <= 1'b0;
      vend_fail   <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nx;
      credit_q    <= credit_nx;
      chg         <= chg_nx;
      price_q     <= price_nx;
      timer       <= timer_nx;
      coin_reject <= reject_nx;
      insuf       <= insuf_nx;
      vend_fail   <= fail_nx;
      done        <= done_nx;
    end
  end

  // chg only moves on the pay_ack that leaves PAYOUT, so pay_coin is stable
  assign pay_coin = (state != PAYOUT) ? 2'd0 :
                    (chg >= 8'd25)    ? 2'd3 :
                    (chg >= 8'd10)    ? 2'd2 : 2'd1;
  assign disp_req = (state == VEND);
  assign pay_req  = (state == PAYOUT);
  assign busy     = (state != IDLE);
  assign credit   = credit_q;

endmodule

// File: tb/tb_vend_txn_controller.sv
// Bench for vend_txn_controller: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_vend_txn_controller;
  localparam int PRICE_A      = 25;
  localparam int PRICE_B      = 40;
  localparam int MAX_CREDIT   = 200;
  localparam int VEND_TIMEOUT = 1000;

  logic clk = 1'b0;
  logic rst, coin10, coin25, sel, buy, cancel, disp_ack, pay_ack;
  logic disp_req, pay_req, busy, coin_reject, insuf, vend_fail, done;
  logic [1:0] pay_coin;
  logic [7:0] credit;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done = 0, n_insuf = 0, n_vfail = 0, n_reject = 0;
  logic [1:0] got_coins[$];

  always #5 clk = ~clk;

  vend_txn_controller #(
    .PRICE_A(PRICE_A), .PRICE_B(PRICE_B),
    .MAX_CREDIT(MAX_CREDIT), .VEND_TIMEOUT(VEND_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .coin10(coin10), .coin25(coin25), .sel(sel),
    .buy(buy), .cancel(cancel), .disp_req(disp_req), .disp_ack(disp_ack),
    .pay_req(pay_req), .pay_coin(pay_coin), .pay_ack(pay_ack),
    .credit(credit), .busy(busy), .coin_reject(coin_reject), .insuf(insuf),
    .vend_fail(vend_fail), .done(done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: phase 0=idle 1=vending 2=paying a coin 3=gap; change is a planned coin list
  int m_mode = 0, m_credit = 0, m_owed = 0, m_refund = 0, m_wait = 0;
  int m_coins[$];
  bit m_reject = 0, m_insuf = 0, m_fail = 0, m_done = 0;

  function automatic void plan_change(input int amt);
    int left = amt;
    m_coins.delete();
    while (left > 0) begin
      if (left >= 25)      begin m_coins.push_back(25); left -= 25; end
      else if (left >= 10) begin m_coins.push_back(10); left -= 10; end
      else                 begin m_coins.push_back(5);  left -= 5;  end
    end
  endfunction

  function automatic void model_step();
    int sum = (coin10 ? 10 : 0) + (coin25 ? 25 : 0);
    int price = sel ? PRICE_B : PRICE_A;
    m_reject = 0; m_insuf = 0; m_fail = 0; m_done = 0;
    if (rst) begin
      m_mode = 0; m_credit = 0; m_owed = 0; m_refund = 0; m_wait = 0;
      m_coins.delete();
    end else begin
      case (m_mode)
        0: begin
          if (cancel && m_credit > 0) begin
            plan_change(m_credit); m_credit = 0; m_mode = 2; m_reject = (sum > 0);
          end else if (buy) begin
            m_reject = (sum > 0);
            if (m_credit >= price) begin
              m_owed = m_credit - price; m_refund = m_credit;
              m_credit = 0; m_wait = 0; m_mode = 1;
            end else m_insuf = 1;
          end else if (sum > 0) begin
            if (m_credit + sum > MAX_CREDIT) m_reject = 1;
            else m_credit += sum;
          end
        end
        1: begin
          m_reject = (sum > 0);
          if (disp_ack) begin
            if (m_owed > 0) begin plan_change(m_owed); m_mode = 2; end
            else begin m_done = 1; m_mode = 0; end
          end else begin
            m_wait++;
            if (m_wait == VEND_TIMEOUT) begin m_fail = 1; plan_change(m_refund); m_mode = 2; end
          end
        end
        2: begin
          m_reject = (sum > 0);
          if (pay_ack) begin void'(m_coins.pop_front()); m_mode = 3; end
        end
        default: begin
          m_reject = (sum > 0);
          if (m_coins.size() > 0) m_mode = 2;
          else begin m_done = 1; m_mode = 0; end
        end
      endcase
    end
  endfunction

  function automatic int exp_code();
    if (m_mode != 2 || m_coins.size() == 0) return 0;
    return (m_coins[0] == 25) ? 3 : (m_coins[0] == 10) ? 2 : 1;
  endfunction

  task automatic compare_cycle();
    check("credit",      credit,      m_credit);
    check("busy",        busy,        (m_mode != 0));
    check("disp_req",    disp_req,    (m_mode == 1));
    check("pay_req",     pay_req,     (m_mode == 2));
    check("pay_coin",    pay_coin,    exp_code());
    check("coin_reject", coin_reject, m_reject);
    check("insuf",       insuf,       m_insuf);
    check("vend_fail",   vend_fail,   m_fail);
    check("done",        done,        m_done);
    if (done)        n_done++;
    if (insuf)       n_insuf++;
    if (vend_fail)   n_vfail++;
    if (coin_reject) n_reject++;
  endtask

  always @(posedge clk) model_step();
  always @(posedge clk) begin
    #1;
    compare_cycle();
  end

  // Stimulus helpers: entered and left on a falling edge
  task automatic coin(input bit c10, input bit c25);
    coin10 = c10; coin25 = c25;
    @(negedge clk);
    coin10 = 0; coin25 = 0;
  endtask

  task automatic do_buy(input bit s);
    sel = s; buy = 1;
    @(negedge clk);
    buy = 0;
  endtask

  task automatic do_cancel();
    cancel = 1;
    @(negedge clk);
    cancel = 0;
  endtask

  task automatic wait_pay_req();
    int k = 0;
    while (!pay_req && k < 50) begin @(negedge clk); k++; end
    check("pay_req_seen", pay_req, 1);
  endtask

  task automatic hopper(input int ncoins);
    for (int i = 0; i < ncoins; i++) begin
      wait_pay_req();
      got_coins.push_back(pay_coin);
      @(negedge clk); @(negedge clk);
      pay_ack = 1;
      @(negedge clk);
      pay_ack = 0;
    end
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 50) begin @(negedge clk); k++; end
    check("done_seen", done, 1);
  endtask

  initial begin
    static int exp5[4] = '{3, 3, 2, 1};
    int k;
    rst = 1; coin10 = 0; coin25 = 0; sel = 0; buy = 0; cancel = 0;
    disp_ack = 0; pay_ack = 0;
    repeat (2) @(negedge clk);
    check("rst_credit", credit, 0);
    check("rst_busy", busy, 0);
    rst = 0;
    @(negedge clk);

    // cancel with no credit does nothing
    do_cancel();
    check("cancel0_busy", busy, 0);

    // 1: exact price, no change
    coin(0, 1);
    check("s1_credit", credit, 25);
    do_buy(0);
    check("s1_disp_req", disp_req, 1);
    check("s1_credit0", credit, 0);
    repeat (2) @(negedge clk);
    disp_ack = 1;
    @(negedge clk);
    disp_ack = 0;
    check("s1_done", done, 1);
    check("s1_idle", busy, 0);

    // 2: 50 for product B, one 10-unit coin of change, explicit GAP cycle
    coin(0, 1); coin(0, 1);
    check("s2_credit", credit, 50);
    do_buy(1);
    disp_ack = 1;
    @(negedge clk);
    disp_ack = 0;
    check("s2_pay_req", pay_req, 1);
    check("s2_pay_coin", pay_coin, 2);
    @(negedge clk);
    pay_ack = 1;
    @(negedge clk);
    pay_ack = 0;
    check("s2_gap_pay_req", pay_req, 0);
    check("s2_gap_busy", busy, 1);
    @(negedge clk);
    check("s2_done", done, 1);
    check("s2_idle", busy, 0);

    // 3: insufficient credit, then cancel refunds the 10
    coin(1, 0);
    do_buy(0);
    check("s3_insuf", insuf, 1);
    check("s3_credit", credit, 10);
    check("s3_idle", busy, 0);
    do_cancel();
    got_coins.delete();
    hopper(1);
    wait_done();
    check("s3_ncoins", got_coins.size(), 1);
    if (got_coins.size() == 1) check("s3_coin", got_coins[0], 2);

    // 4: double coin, credit ceiling boundary
    coin(1, 1);
    check("s4_both", credit, 35);
    repeat (5) coin(0, 1);
    repeat (3) coin(1, 0);
    check("s4_190", credit, 190);
    coin(0, 1);
    check("s4_reject25", coin_reject, 1);
    check("s4_keep190", credit, 190);
    coin(1, 0);
    check("s4_200", credit, 200);
    coin(1, 0);
    check("s4_reject10", coin_reject, 1);
    check("s4_keep200", credit, 200);
    do_cancel();
    got_coins.delete();
    hopper(8);
    wait_done();
    check("s4_ncoins", got_coins.size(), 8);
    foreach (got_coins[i]) check("s4_coin", got_coins[i], 3);

    // 5: dispenser timeout, full refund of 65 as 25,25,10,5
    coin(0, 1);
    repeat (4) coin(1, 0);
    check("s5_credit", credit, 65);
    do_buy(1);
    coin(1, 0);
    check("s5_vend_reject", coin_reject, 1);
    do_buy(0);
    check("s5_buy_ignored", disp_req, 1);
    k = 0;
    while (!vend_fail && k < VEND_TIMEOUT + 100) begin @(negedge clk); k++; end
    check("s5_vend_fail", vend_fail, 1);
    check("s5_timeout_cycles", k, VEND_TIMEOUT - 2);
    got_coins.delete();
    hopper(4);
    wait_done();
    check("s5_ncoins", got_coins.size(), 4);
    if (got_coins.size() == 4)
      for (int i = 0; i < 4; i++) check("s5_coin", got_coins[i], exp5[i]);

    // 6: reset in the middle of a payout
    coin(0, 1); coin(0, 1);
    do_cancel();
    wait_pay_req();
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("s6_pay_req", pay_req, 0);
    check("s6_pay_coin", pay_coin, 0);
    check("s6_disp_req", disp_req, 0);
    check("s6_busy", busy, 0);
    check("s6_credit", credit, 0);
    check("s6_done", done, 0);
    pay_ack = 1;
    @(negedge clk);
    pay_ack = 0;
    @(negedge clk);
    check("s6_ack_ignored", busy, 0);
    coin(0, 1);
    check("s6_after", credit, 25);
    @(negedge clk);

    check("cnt_done", n_done, 5);
    check("cnt_insuf", n_insuf, 1);
    check("cnt_vend_fail", n_vfail, 1);
    check("cnt_reject", n_reject, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
